axis_pl_to_ps: RTL and testbench



---
 rtl/axis_pl_to_ps.sv | 117 +++++++++++
 tb/tb_axis_pl_to_ps.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pl_to_ps.sv
// axis_pl_to_ps: 256-bit to ps_axis_width AXIS downconverter for the PL-to-PS return path.
// Each wide word is emitted MSB slice first. A skid register keeps the output stream
// gap-free, and tlast can optionally be generated every pkt_words narrow beats.
module axis_pl_to_ps #(
  parameter int unsigned ps_axis_width = 32,
  parameter int unsigned pkt_words     = 0
) (
  input  logic                     ps_clk,
  input  logic                     rst,
  input  logic [255:0]             s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [ps_axis_width-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);

  localparam int unsigned wide_w    = 256;
  localparam int unsigned cnt_w     = 16;
  localparam int unsigned ps_per_pl = wide_w / ps_axis_width;
  localparam logic [cnt_w-1:0] last_slice_idx = cnt_w'(ps_per_pl - 1);
  localparam logic [cnt_w-1:0] last_beat_idx  = cnt_w'(pkt_words - 1);
  localparam logic             tlast_en       = (pkt_words != 0);

  // Reject unsupported narrow widths and packet lengths at elaboration.
  if (!(ps_axis_width == 8 || ps_axis_width == 16 || ps_axis_width == 32 ||
        ps_axis_width == 64 || ps_axis_width == 128)) begin : g_bad_width
    $error("axis_pl_to_ps: ps_axis_width must be 8/16/32/64/128");
  end
  if (pkt_words > 65535) begin : g_bad_pkt
    $error("axis_pl_to_ps: pkt_words must be 0..65535");
  end

  logic [wide_w-1:0] active_q, active_d;
  logic [wide_w-1:0] hold_q, hold_d;
  logic              active_valid_q, active_valid_d;
  logic              hold_valid_q, hold_valid_d;
  logic [cnt_w-1:0]  slice_cnt_q, slice_cnt_d;
  logic [cnt_w-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              in_hs;
  logic              out_hs;
  logic              last_slice;
  logic              finishing;

  // Handshakes and outputs, all decoded from registered state.
  assign s_axis_tready = !hold_valid_q && !rst;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = active_valid_q && m_axis_tready;
  assign last_slice    = (slice_cnt_q == last_slice_idx);
  assign finishing     = out_hs && last_slice;
  assign m_axis_tvalid = active_valid_q;
  assign m_axis_tdata  = active_q[wide_w-1 -: ps_axis_width];
  assign m_axis_tlast  = tlast_en && active_valid_q && (pkt_cnt_q == last_beat_idx);

  // Next-state: slice shifting, wide-word routing between input/active/hold, packet count.
  always_comb begin
    active_d       = active_q;
    hold_d         = hold_q;
    active_valid_d = active_valid_q;
    hold_valid_d   = hold_valid_q;
    slice_cnt_d    = slice_cnt_q;
    pkt_cnt_d      = pkt_cnt_q;

    if (out_hs && !last_slice) begin
      active_d    = active_q << ps_axis_width;
      slice_cnt_d = slice_cnt_q + cnt_w'(1);
    end

    if (finishing) begin
      slice_cnt_d = '0;
      if (hold_valid_q) begin
        // Input is blocked this cycle because tready is low while hold is full.
        active_d     = hold_q;
        hold_valid_d = 1'b0;
      end else if (in_hs) begin
        active_d = s_axis_tdata;
      end else begin
        active_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      if (!active_valid_q) begin
        active_d       = s_axis_tdata;
        active_valid_d = 1'b1;
        slice_cnt_d    = '0;
      end else begin
        hold_d       = s_axis_tdata;
        hold_valid_d = 1'b1;
      end
    end

    // Packet counter ignores wide-word boundaries.
    if (tlast_en && out_hs) begin
      pkt_cnt_d = m_axis_tlast ? '0 : pkt_cnt_q + cnt_w'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ps_clk) begin
    if (rst) begin
      active_q       <= '0;
      hold_q         <= '0;
      active_valid_q <= 1'b0;
      hold_valid_q   <= 1'b0;
      slice_cnt_q    <= '0;
      pkt_cnt_q      <= '0;
    end else begin
      active_q       <= active_d;
      hold_q         <= hold_d;
      active_valid_q <= active_valid_d;
      hold_valid_q   <= hold_valid_d;
      slice_cnt_q    <= slice_cnt_d;
      pkt_cnt_q      <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_pl_to_ps.sv
// Testbench for axis_pl_to_ps: a 32-bit/pkt_words=12 instance driven by randomized traffic
// against a beat queue model, plus 64- and 128-bit instances checked by rebuilding wide words.
module tb_axis_pl_to_ps;

  logic         ps_clk;
  logic         rst;
  logic [255:0] s_data;
  logic         s_valid, s_ready;
  logic [31:0]  m_data;
  logic         m_valid, m_ready, m_last;

  logic [255:0] s64_data, s128_data;
  logic         s64_valid, s64_ready, s128_valid, s128_ready;
  logic [63:0]  m64_data;
  logic [127:0] m128_data;
  logic         m64_valid, m64_last, m128_valid, m128_last, wm_ready;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic        eow;
  } beat_t;

  beat_t        exp_q[$];
  int           beat_total = 0;
  logic [255:0] words[$];

  axis_pl_to_ps #(.ps_axis_width(32), .pkt_words(12)) dut (
    .ps_clk(ps_clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last)
  );

  axis_pl_to_ps #(.ps_axis_width(64), .pkt_words(0)) dut64 (
    .ps_clk(ps_clk), .rst(rst),
    .s_axis_tdata(s64_data), .s_axis_tvalid(s64_valid), .s_axis_tready(s64_ready),
    .m_axis_tdata(m64_data), .m_axis_tvalid(m64_valid), .m_axis_tready(wm_ready),
    .m_axis_tlast(m64_last)
  );

  axis_pl_to_ps #(.ps_axis_width(128), .pkt_words(0)) dut128 (
    .ps_clk(ps_clk), .rst(rst),
    .s_axis_tdata(s128_data), .s_axis_tvalid(s128_valid), .s_axis_tready(s128_ready),
    .m_axis_tdata(m128_data), .m_axis_tvalid(m128_valid), .m_axis_tready(wm_ready),
    .m_axis_tlast(m128_last)
  );

  initial begin
    ps_clk = 1'b0;
    forever #5 ps_clk = ~ps_clk;
  end

  task automatic tick();
    @(posedge ps_clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model: a wide word becomes 8 beats, top slice first; tlast every 12th beat since reset.
  task automatic push_word(input logic [255:0] w);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.d    = w[255-32*k -: 32];
      b.last = ((beat_total % 12) == 11);
      b.eow  = (k == 7);
      beat_total++;
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    s64_valid = 1'b0; s128_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    beat_total = 0;
  endtask

  // Scenario engine: offers words[0..n-1], applies a ready pattern, scoreboards every beat.
  // rmode 0: ready=1; 1: ready pattern 1,0,0,1; 2: random ready and random input gaps.
  task automatic run_traffic(input int n, input int rmode, output int acc_cyc,
                             output int first_cyc, output int gaps, output int lasts);
    int    widx = 0;
    int    inflight = 0;
    bit    offering = 0;
    bit    done = 0;
    bit    prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic  prev_last = 1'b0;
    beat_t b;
    acc_cyc = -1; first_cyc = -1; gaps = 0; lasts = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!offering && widx < n && (rmode != 2 || $urandom_range(0, 2) != 0)) begin
        offering = 1;
        s_data = words[widx];
      end
      s_valid = offering;
      if (rmode == 0)      m_ready = 1'b1;
      else if (rmode == 1) m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      else                 m_ready = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (s_ready !== 1'(inflight < 2)) begin
        n_fail++;
        $display("FAIL s_ready cyc=%0d got=%b want=%b", c, s_ready, inflight < 2);
      end
      if (prev_stall) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   c, m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid === 1'b1 && first_cyc < 0) first_cyc = c;
      if (first_cyc >= 0 && m_valid !== 1'b1 && exp_q.size() != 0) gaps++;
      if (m_valid === 1'b1 && exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL spurious_valid cyc=%0d got d=%h want no beat", c, m_data);
      end else if (m_valid !== 1'b1 && m_last !== 1'b0) begin
        n_cmp++; n_fail++;
        $display("FAIL idle_tlast cyc=%0d got=%b want=0", c, m_last);
      end else if (m_valid === 1'b1 && m_ready) begin
        b = exp_q.pop_front();
        n_cmp++;
        if (m_data !== b.d || m_last !== b.last) begin
          n_fail++;
          $display("FAIL beat cyc=%0d got d=%h l=%b want d=%h l=%b",
                   c, m_data, m_last, b.d, b.last);
        end
        if (m_last === 1'b1) lasts++;
        if (b.eow) inflight--;
      end
      if (s_valid && s_ready === 1'b1) begin
        push_word(words[widx]);
        inflight++;
        widx++;
        offering = 0;
        if (acc_cyc < 0) acc_cyc = c;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      tick();
      if (widx == n && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    s_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL traffic_timeout got accepted=%0d pending=%0d want accepted=%0d pending=0",
               widx, exp_q.size(), n);
    end else if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after got tvalid=%b want 0", m_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = rand256(); m_ready = 1'b1;
    s64_valid = 1'b0; s128_valid = 1'b0; wm_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h l=%b want v=0 d=0 l=0", m_valid, m_data, m_last);
    end
    n_cmp++;
    if (s_ready !== 1'b0 || s64_ready !== 1'b0 || s128_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tready got %b%b%b want 000", s_ready, s64_ready, s128_ready);
    end
    rst = 1'b0; s_valid = 1'b0;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_tready got=%b want=1", s_ready);
    end
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || m64_valid !== 1'b0 || m128_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_capture got %b%b%b want 000", m_valid, m64_valid, m128_valid);
    end
    exp_q.delete();
    beat_total = 0;
  endtask

  task automatic test_single_word();
    int a, f, g, l;
    words.delete();
    words.push_back(256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);
    run_traffic(1, 0, a, f, g, l);
    n_cmp++;
    if (f != a + 1 || g != 0) begin
      n_fail++;
      $display("FAIL single_latency got first=%0d gaps=%0d want first=%0d gaps=0", f, g, a + 1);
    end
  endtask

  task automatic test_back_to_back();
    int a, f, g, l;
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(rand256());
    run_traffic(3, 0, a, f, g, l);
    n_cmp++;
    if (g != 0 || f != a + 1) begin
      n_fail++;
      $display("FAIL b2b_gaps got gaps=%0d first=%0d want gaps=0 first=%0d", g, f, a + 1);
    end
  endtask

  task automatic test_backpressure();
    int a, f, g, l;
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(rand256());
    run_traffic(4, 1, a, f, g, l);
  endtask

  task automatic test_tlast();
    int a, f, g, l;
    do_reset();
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(rand256());
    run_traffic(3, 0, a, f, g, l);
    n_cmp++;
    if (l != 2) begin
      n_fail++;
      $display("FAIL tlast_count got=%0d want=2", l);
    end
  endtask

  task automatic test_random();
    int a, f, g, l;
    for (int r = 0; r < 4; r++) begin
      words.delete();
      for (int i = 0; i < 5; i++) words.push_back(rand256());
      run_traffic(5, 2, a, f, g, l);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [255:0] wa, wb, wn;
    int a, f, g, l;
    do_reset();
    wa = rand256(); wb = rand256();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_valid = (k < 2);
      s_data  = (k == 0) ? wa : wb;
      #1;
      if (k > 0) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== wa[255-32*(k-1) -: 32]) begin
          n_fail++;
          $display("FAIL pre_reset_beat k=%0d got v=%b d=%h want v=1 d=%h",
                   k, m_valid, m_data, wa[255-32*(k-1) -: 32]);
        end
      end
      tick();
    end
    rst = 1'b1; m_ready = 1'b0; s_valid = 1'b1; s_data = rand256();
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_tready got=%b want=0", s_ready);
    end
    tick();
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset got v=%b d=%h l=%b rdy=%b want v=0 d=0 l=0 rdy=1",
               m_valid, m_data, m_last, s_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_beat k=%0d got tvalid=%b want 0", k, m_valid);
      end
    end
    exp_q.delete();
    beat_total = 0;
    wn = rand256();
    wn[255:248] = 8'hA5;
    words.delete();
    words.push_back(wn);
    words.push_back(rand256());
    run_traffic(2, 0, a, f, g, l);
    n_cmp++;
    if (l != 1) begin
      n_fail++;
      $display("FAIL post_reset_tlast got=%0d want=1", l);
    end
  endtask

  // Wide instances: rebuild each word from its beats (MSB first) and compare to what was sent.
  task automatic test_width_sweep();
    logic [255:0] wq[$];
    logic [255:0] acc64 = '0, acc128 = '0;
    int in64 = 0, out64 = 0, k64 = 0, in128 = 0, out128 = 0, k128 = 0;
    for (int i = 0; i < 3; i++) wq.push_back(rand256());
    wm_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      s64_valid  = (in64 < 3);
      s64_data   = (in64 < 3) ? wq[in64] : '0;
      s128_valid = (in128 < 3);
      s128_data  = (in128 < 3) ? wq[in128] : '0;
      #1;
      if (m64_valid === 1'b1) begin
        acc64 = {acc64[191:0], m64_data};
        k64++;
        n_cmp++;
        if (m64_last !== 1'b0 || out64 >= 3) begin
          n_fail++;
          $display("FAIL w64_beat got last=%b word=%0d want last=0 word<3", m64_last, out64);
        end
        if (k64 == 4 && out64 < 3) begin
          n_cmp++;
          if (acc64 !== wq[out64]) begin
            n_fail++;
            $display("FAIL w64_word got=%h want=%h", acc64, wq[out64]);
          end
          out64++; k64 = 0;
        end
      end
      if (m128_valid === 1'b1) begin
        acc128 = {acc128[127:0], m128_data};
        k128++;
        n_cmp++;
        if (m128_last !== 1'b0 || out128 >= 3) begin
          n_fail++;
          $display("FAIL w128_beat got last=%b word=%0d want last=0 word<3", m128_last, out128);
        end
        if (k128 == 2 && out128 < 3) begin
          n_cmp++;
          if (acc128 !== wq[out128]) begin
            n_fail++;
            $display("FAIL w128_word got=%h want=%h", acc128, wq[out128]);
          end
          out128++; k128 = 0;
        end
      end
      if (s64_valid && s64_ready === 1'b1) in64++;
      if (s128_valid && s128_ready === 1'b1) in128++;
      tick();
    end
    s64_valid = 1'b0; s128_valid = 1'b0;
    n_cmp++;
    if (out64 != 3 || out128 != 3 || k64 != 0 || k128 != 0) begin
      n_fail++;
      $display("FAIL width_sweep_count got w64=%0d.%0d w128=%0d.%0d want 3.0 and 3.0",
               out64, k64, out128, k128);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    s64_valid = 1'b0; s64_data = '0; s128_valid = 1'b0; s128_data = '0; wm_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_tlast();
    test_random();
    test_reset_mid_word();
    test_width_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
